dcache_responder: RTL and testbench
===================================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter NSETS, default 16, number of direct-mapped sets (power of two, one 32-bit word per set).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 halt  input  1  datapath halted; start write-back flush.
REQ-005 dmemREN  input  1  datapath read request, held stable until dhit.
REQ-006 dmemWEN  input  1  datapath write request, held stable until dhit.
REQ-007 dmemaddr  input  32  request byte address: [1:0] ignored, index [log2(NSETS)+1:2], tag above.
REQ-008 dmemstore  input  32  write data.
REQ-009 dhit  output  1  request serviced this cycle.
REQ-010 dmemload  output  32  read data, valid when dhit on a read.
REQ-011 flushed  output  1  flush complete.
REQ-012 dREN  output  1  memory read request.
REQ-013 dWEN  output  1  memory write request.
REQ-014 daddr  output  32  memory word address, [1:0]=00.
REQ-015 dstore  output  32  memory write data.
REQ-016 dload  input  32  memory read data, valid when dwait=0.
REQ-017 dwait  input  1  memory busy; a dREN/dWEN transfer completes in the cycle dwait=0.

Function
REQ-018 Per set: valid bit, dirty bit, tag, 32-bit data word.
REQ-019 States: IDLE, WB, FETCH, FLUSH, HALTED.
REQ-020 IDLE hit (valid and tag match, dmemREN or dmemWEN): dhit=1 combinationally in same cycle, zero added latency.
REQ-021 Read hit: dmemload = set data; dmemload = 0 whenever not a read hit.
REQ-022 Write hit: at the edge, data<=dmemstore, dirty<=1; dmemWEN takes priority if both requests asserted.
REQ-023 IDLE miss, victim valid and dirty -> WB; otherwise -> FETCH; dhit=0.
REQ-024 WB: dWEN=1, daddr={victim tag, index, 00}, dstore=victim data; on dwait=0 -> FETCH.
REQ-025 FETCH: dREN=1, daddr={request tag, index, 00}; on dwait=0 write dload, tag, valid=1, dirty=0, -> IDLE; request then hits in IDLE (write hit sets dirty).
REQ-026 Clean miss latency with dwait=0 on first cycle: dhit in 2nd cycle after request; dirty miss: 3rd cycle.
REQ-027 halt sampled only in IDLE and takes priority over a concurrent request -> FLUSH, set counter=0.
REQ-028 FLUSH: if set[counter] valid and dirty, dWEN=1 with its address/data, hold until dwait=0, then clear dirty and increment; else increment in one cycle without memory access.
REQ-029 FLUSH after set NSETS-1 completes -> HALTED; HALTED is terminal until reset, flushed=1.
REQ-030 dhit=0 in WB, FETCH, FLUSH, HALTED; dREN and dWEN never asserted together.
REQ-031 dREN, dWEN, daddr, dstore = 0 when no memory transfer is active.

Reset
REQ-032 RST asserted: immediately state=IDLE, all valid and dirty=0, counter=0, every output 0, regardless of state (including mid-WB/FETCH/FLUSH); tags/data need not be cleared.
REQ-033 First edge after RST deasserts behaves as IDLE with empty cache.

Verification
REQ-034 Reset, read 0x00000040, memory returns 0xDEADBEEF with dwait=0 -> one FETCH cycle dREN=1 daddr=0x40, next cycle dhit=1 dmemload=0xDEADBEEF.
REQ-035 Write 0x12345678 to 0x40 after REQ-034 fill -> dhit same cycle, no memory access; read 0x40 -> 0x12345678.
REQ-036 Read 0x80 (same index, different tag) after REQ-035 -> WB dWEN=1 daddr=0x40 dstore=0x12345678, then FETCH daddr=0x80; dhit only after both complete.
REQ-037 dwait held 1 for 3 cycles in FETCH -> dREN/daddr held stable, dhit=0 until fill, then hit.
REQ-038 Dirty sets 2 and 5 only, halt -> exactly two dWEN transfers at their addresses, NSETS cycles plus wait cycles, then flushed=1 held; requests ignored with dhit=0.
REQ-039 RST pulse during WB with dwait=1 -> dWEN drops at once, flushed=0, previously valid address misses afterward.

Source files
------------

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache, one word per set; hits answer in the same cycle,
// misses stall the datapath through optional write-back then fetch; halt flushes dirty sets.
module dcache_responder #(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);

    localparam int IW = $clog2(NSETS);
    localparam int TW = 30 - IW;
    localparam logic [IW-1:0] LAST_SET = IW'(NSETS - 1);

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, HALTED} state_t;

    state_t          state, state_next;
    logic [NSETS-1:0] valid, dirty;
    logic [TW-1:0]   tags [NSETS];
    logic [31:0]     data [NSETS];
    logic [IW-1:0]   cnt, cnt_next;

    logic [IW-1:0]   idx;
    logic [TW-1:0]   tag;
    logic            hit;
    logic            fill_en, wr_en, clr_en;
    logic            unused_addr_bits;

    assign idx = dmemaddr[IW+1:2];
    assign tag = dmemaddr[31:IW+2];
    assign hit = valid[idx] && (tags[idx] == tag);
    assign unused_addr_bits = ^dmemaddr[1:0];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dhit       = 1'b0;
        dmemload   = '0;
        flushed    = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        fill_en    = 1'b0;
        wr_en      = 1'b0;
        clr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (halt) begin
                    state_next = FLUSH;
                    cnt_next   = '0;
                end else if (dmemREN || dmemWEN) begin
                    if (hit) begin
                        dhit = 1'b1;
                        if (dmemWEN) wr_en = 1'b1;
                        else         dmemload = data[idx];
                    end else if (valid[idx] && dirty[idx]) begin
                        state_next = WB;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tags[idx], idx, 2'b00};
                dstore = data[idx];
                if (!dwait) state_next = FETCH;
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {tag, idx, 2'b00};
                if (!dwait) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                // Clean or invalid sets cost one cycle; dirty sets wait for the memory.
                if (valid[cnt] && dirty[cnt]) begin
                    dWEN   = 1'b1;
                    daddr  = {tags[cnt], cnt, 2'b00};
                    dstore = data[cnt];
                    if (!dwait) begin
                        clr_en   = 1'b1;
                        cnt_next = cnt + 1'b1;
                        if (cnt == LAST_SET) state_next = HALTED;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == LAST_SET) state_next = HALTED;
                end
            end
            HALTED: flushed = 1'b1;
            default: state_next = IDLE;
        endcase
        if (RST) begin
            dhit     = 1'b0;
            dmemload = '0;
            flushed  = 1'b0;
            dREN     = 1'b0;
            dWEN     = 1'b0;
            daddr    = '0;
            dstore   = '0;
            fill_en  = 1'b0;
            wr_en    = 1'b0;
            clr_en   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (fill_en) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (wr_en)  dirty[idx] <= 1'b1;
            if (clr_en) dirty[cnt] <= 1'b0;
        end
    end

    // Tag and data storage carry no reset; validity alone decides a hit.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tags[idx] <= tag;
            data[idx] <= dload;
        end
        if (wr_en) data[idx] <= dmemstore;
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: a word memory model answers dREN/dWEN,
// expected loads, fetch addresses and write-backs are queued and compared on completion.
module tb_dcache_responder;

    logic        CLK = 1'b0;
    logic        RST, halt, dmemREN, dmemWEN, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    dcache_responder #(.NSETS(16)) dut (
        .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;

    logic [31:0] mem    [256];
    logic [31:0] golden [256];
    logic [31:0] exp_load_q[$];
    logic [31:0] exp_rd_q[$], obs_rd_q[$];
    logic [31:0] exp_wb_addr_q[$], exp_wb_dat_q[$], obs_wb_addr_q[$], obs_wb_dat_q[$];

    int          wait_cfg = 0, wait_cnt = 0, overlap = 0, unstable = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] last_addr = '0;

    // Memory model, called once per negedge: drives dwait/dload and logs finished transfers.
    task serve_mem();
        if (dREN && dWEN) overlap++;
        if (prev_wait && (daddr !== last_addr)) unstable++;
        if (dREN || dWEN) begin
            if (wait_cnt < wait_cfg) begin
                dwait = 1'b1;
                wait_cnt++;
            end else begin
                dwait = 1'b0;
                wait_cnt = 0;
                if (dREN) begin
                    dload = mem[daddr[9:2]];
                    obs_rd_q.push_back(daddr);
                end else begin
                    mem[daddr[9:2]] = dstore;
                    obs_wb_addr_q.push_back(daddr);
                    obs_wb_dat_q.push_back(dstore);
                end
            end
            prev_wait = dwait;
            last_addr = daddr;
        end else begin
            dwait = 1'b0;
            prev_wait = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                input int wcfg, output int lat, output logic [31:0] load);
        wait_cfg  = wcfg;
        dmemaddr  = addr;
        dmemstore = wdata;
        dmemWEN   = wr;
        dmemREN   = !wr;
        if (wr) golden[addr[9:2]] = wdata;
        else    exp_load_q.push_back(golden[addr[9:2]]);
        lat  = -1;
        load = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            serve_mem();
            if (dhit) begin
                lat  = c;
                load = dmemload;
                break;
            end
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    function automatic logic [31:0] pop32(inout logic [31:0] q[$]);
        if (q.size() == 0) return 32'hFFFF_FFFF;
        return q.pop_front();
    endfunction

    task test_reset();
        RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        dmemaddr = '0; dmemstore = '0; dload = '0; dwait = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (dhit !== 1'b0)     $display("FAIL rst_dhit got %b want 0", dhit); else passed++;
        checks++; if (dREN !== 1'b0 || dWEN !== 1'b0) $display("FAIL rst_mem_req got %b%b want 00", dREN, dWEN); else passed++;
        checks++; if (daddr !== 32'h0 || dstore !== 32'h0) $display("FAIL rst_bus got %h/%h want 0/0", daddr, dstore); else passed++;
        checks++; if (flushed !== 1'b0)  $display("FAIL rst_flushed got %b want 0", flushed); else passed++;
        checks++; if (dmemload !== 32'h0) $display("FAIL rst_dmemload got %h want 0", dmemload); else passed++;
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task test_clean_miss();
        int lat; logic [31:0] ld;
        mem[8'h10] = 32'hDEADBEEF; golden[8'h10] = 32'hDEADBEEF;
        exp_rd_q.push_back(32'h40);
        access(1'b0, 32'h40, 32'h0, 0, lat, ld);
        checks++; if (lat !== 2) $display("FAIL clean_miss_latency got %0d want 2", lat); else passed++;
        checks++; if (ld !== pop32(exp_load_q)) $display("FAIL clean_miss_load got %h", ld); else passed++;
        checks++; if (pop32(obs_rd_q) !== pop32(exp_rd_q)) $display("FAIL clean_miss_fetch_addr wrong or missing, want 00000040"); else passed++;
    endtask

    task test_write_hit();
        int lat; logic [31:0] ld;
        access(1'b1, 32'h40, 32'h12345678, 0, lat, ld);
        checks++; if (lat !== 0) $display("FAIL write_hit_latency got %0d want 0", lat); else passed++;
        checks++; if (ld !== 32'h0) $display("FAIL write_hit_dmemload got %h want 0", ld); else passed++;
        checks++; if (obs_rd_q.size() + obs_wb_addr_q.size() != 0) $display("FAIL write_hit_mem_access got %0d transfers want 0", obs_rd_q.size() + obs_wb_addr_q.size()); else passed++;
        access(1'b0, 32'h40, 32'h0, 0, lat, ld);
        checks++; if (lat !== 0) $display("FAIL read_hit_latency got %0d want 0", lat); else passed++;
        checks++; if (ld !== pop32(exp_load_q)) $display("FAIL read_hit_load got %h want 12345678", ld); else passed++;
        checks++; if (mem[8'h10] !== 32'hDEADBEEF) $display("FAIL write_hit_no_writethrough got %h want deadbeef", mem[8'h10]); else passed++;
    endtask

    task test_dirty_miss();
        int lat; logic [31:0] ld;
        mem[8'h20] = 32'hCAFEF00D; golden[8'h20] = 32'hCAFEF00D;
        exp_wb_addr_q.push_back(32'h40); exp_wb_dat_q.push_back(32'h12345678);
        exp_rd_q.push_back(32'h80);
        access(1'b0, 32'h80, 32'h0, 0, lat, ld);
        checks++; if (lat !== 3) $display("FAIL dirty_miss_latency got %0d want 3", lat); else passed++;
        checks++; if (ld !== pop32(exp_load_q)) $display("FAIL dirty_miss_load got %h want cafef00d", ld); else passed++;
        checks++; if (pop32(obs_wb_addr_q) !== pop32(exp_wb_addr_q)) $display("FAIL dirty_miss_wb_addr wrong or missing, want 00000040"); else passed++;
        checks++; if (pop32(obs_wb_dat_q) !== pop32(exp_wb_dat_q)) $display("FAIL dirty_miss_wb_data wrong or missing, want 12345678"); else passed++;
        checks++; if (pop32(obs_rd_q) !== pop32(exp_rd_q)) $display("FAIL dirty_miss_fetch_addr wrong or missing, want 00000080"); else passed++;
    endtask

    task test_fetch_wait();
        int lat; logic [31:0] ld;
        mem[8'h30] = 32'h0BADCAFE; golden[8'h30] = 32'h0BADCAFE;
        exp_rd_q.push_back(32'hC0);
        unstable = 0;
        access(1'b0, 32'hC0, 32'h0, 3, lat, ld);
        checks++; if (lat !== 5) $display("FAIL fetch_wait_latency got %0d want 5", lat); else passed++;
        checks++; if (ld !== pop32(exp_load_q)) $display("FAIL fetch_wait_load got %h want 0badcafe", ld); else passed++;
        checks++; if (unstable !== 0) $display("FAIL fetch_wait_addr_stable got %0d changes want 0", unstable); else passed++;
        checks++; if (pop32(obs_rd_q) !== pop32(exp_rd_q)) $display("FAIL fetch_wait_addr wrong or missing, want 000000c0"); else passed++;
        checks++; if (obs_wb_addr_q.size() != 0) $display("FAIL fetch_wait_clean_victim got %0d writebacks want 0", obs_wb_addr_q.size()); else passed++;
    endtask

    task test_back_to_back();
        int lat; logic [31:0] ld;
        access(1'b1, 32'h08, 32'h22222222, 0, lat, ld);
        checks++; if (lat !== 2) $display("FAIL write_miss_set2_latency got %0d want 2", lat); else passed++;
        access(1'b1, 32'h14, 32'h55555555, 0, lat, ld);
        checks++; if (lat !== 2) $display("FAIL write_miss_set5_latency got %0d want 2", lat); else passed++;
        obs_rd_q.delete();
        access(1'b0, 32'h08, 32'h0, 0, lat, ld);
        checks++; if (lat !== 0 || ld !== pop32(exp_load_q)) $display("FAIL b2b_read_set2 got lat %0d data %h want 0/22222222", lat, ld); else passed++;
        access(1'b0, 32'h14, 32'h0, 0, lat, ld);
        checks++; if (lat !== 0 || ld !== pop32(exp_load_q)) $display("FAIL b2b_read_set5 got lat %0d data %h want 0/55555555", lat, ld); else passed++;
    endtask

    task test_flush();
        int t, hit_seen, bad;
        exp_wb_addr_q.push_back(32'h08); exp_wb_dat_q.push_back(32'h22222222);
        exp_wb_addr_q.push_back(32'h14); exp_wb_dat_q.push_back(32'h55555555);
        wait_cfg = 1; wait_cnt = 0; hit_seen = 0; t = 0;
        halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h08;
        @(negedge CLK);
        serve_mem();
        checks++; if (dhit !== 1'b0) $display("FAIL halt_priority_dhit got %b want 0", dhit); else passed++;
        for (int c = 0; c < 60; c++) begin
            @(posedge CLK); #1;
            halt = 1'b0;
            @(negedge CLK);
            t++;
            serve_mem();
            if (dhit) hit_seen++;
            if (flushed) break;
        end
        checks++; if (t !== 19) $display("FAIL flush_cycles got %0d want 19", t); else passed++;
        checks++; if (hit_seen !== 0) $display("FAIL flush_dhit got %0d hits want 0", hit_seen); else passed++;
        for (int i = 0; i < 2; i++) begin
            checks++; if (pop32(obs_wb_addr_q) !== pop32(exp_wb_addr_q) || pop32(obs_wb_dat_q) !== pop32(exp_wb_dat_q))
                $display("FAIL flush_writeback_%0d wrong or missing address/data", i); else passed++;
        end
        checks++; if (obs_wb_addr_q.size() != 0) $display("FAIL flush_extra_writebacks got %0d want 0", obs_wb_addr_q.size()); else passed++;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            if (flushed !== 1'b1 || dhit !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL halted_terminal got %0d bad cycles want 0", bad); else passed++;
        dmemREN = 1'b0;
        wait_cfg = 0;
    endtask

    task test_reset_mid_wb();
        int lat; logic [31:0] ld;
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        checks++; if (flushed !== 1'b0) $display("FAIL rst_after_halt_flushed got %b want 0", flushed); else passed++;
        for (int i = 0; i < 256; i++) golden[i] = mem[i];
        obs_rd_q.delete(); obs_wb_addr_q.delete(); obs_wb_dat_q.delete();
        access(1'b1, 32'h0C, 32'h33333333, 0, lat, ld);
        checks++; if (lat !== 2) $display("FAIL set3_write_miss_latency got %0d want 2", lat); else passed++;
        golden[3] = mem[3];
        dmemREN = 1'b1; dmemaddr = 32'h10C; dwait = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if (dWEN !== 1'b1 || daddr !== 32'h0C) $display("FAIL mid_wb_active got dWEN %b addr %h want 1/0000000c", dWEN, daddr); else passed++;
        #1 RST = 1'b1;
        #1;
        checks++; if (dWEN !== 1'b0 || daddr !== 32'h0 || dstore !== 32'h0) $display("FAIL mid_wb_reset_drop got dWEN %b addr %h data %h want 0", dWEN, daddr, dstore); else passed++;
        checks++; if (flushed !== 1'b0 || dhit !== 1'b0) $display("FAIL mid_wb_reset_flags got %b%b want 00", flushed, dhit); else passed++;
        @(negedge CLK); RST = 1'b0; dmemREN = 1'b0; dwait = 1'b0;
        @(posedge CLK); #1;
        access(1'b0, 32'h0C, 32'h0, 0, lat, ld);
        checks++; if (lat !== 2) $display("FAIL post_reset_miss_latency got %0d want 2", lat); else passed++;
        checks++; if (ld !== pop32(exp_load_q)) $display("FAIL post_reset_load got %h want a0000003", ld); else passed++;
        checks++; if (mem[3] !== 32'hA0000003) $display("FAIL aborted_wb_reached_mem got %h want a0000003", mem[3]); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'hA000_0000 | 32'(i);
            golden[i] = mem[i];
        end
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_miss();
        test_fetch_wait();
        test_back_to_back();
        test_flush();
        test_reset_mid_wb();
        checks++; if (overlap !== 0) $display("FAIL dren_dwen_overlap got %0d cycles want 0", overlap); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
